reg_bus_initiator: RTL and testbench
====================================

REG_BUS_INITIATOR -- requirements
Module: reg_bus_initiator

Interface
REQ-001 SHALL have parameter NREGS, default 8, number of attached register words.
REQ-002 SHALL have parameter DW, default 8, data bits per register word.
REQ-003 SHALL have parameter AW, default 3, command address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_sel_ab  input  1  write source select forwarded to registers.
REQ-010 SHALL have port cmd_addr  input  AW  target register word index.
REQ-011 SHALL have port cmd_wdata  input  DW  write data.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 SHALL have port rsp_rdata  output  DW  read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_err  output  1  address out of range.
REQ-016 SHALL have port reg_sel  output  NREGS  one-hot word select.
REQ-017 SHALL have port reg_read  output  1  read strobe, gates register ro outputs.
REQ-018 SHALL have port reg_write  output  1  write strobe.
REQ-019 SHALL have port reg_sel_ab  output  1  registered copy of cmd_sel_ab.
REQ-020 SHALL have port reg_wdata  output  DW  registered copy of cmd_wdata, drives register in_a/in_b.
REQ-021 SHALL have port reg_ro  input  NREGS*DW  concatenated ro outputs, word i at bits [i*DW +: DW].

Function
REQ-022 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-023 IDLE: cmd_ready=1; on cmd_valid latch write, sel_ab, addr, wdata, go SETUP.
REQ-024 SETUP (1 cycle): drive reg_sel, reg_wdata, reg_sel_ab; reg_read=reg_write=0; go ACCESS.
REQ-025 ACCESS (1 cycle): assert exactly one of reg_write or reg_read per latched command, keep reg_sel stable; go RESP.
REQ-026 Read data SHALL be captured at the ACCESS clock edge as OR-reduction over words of (reg_ro word AND reg_sel bit).
REQ-027 Out-of-range addr (>= NREGS): reg_sel all zero, no strobe in ACCESS, rsp_err=1, rsp_rdata=0.
REQ-028 RESP: rsp_valid=1 with stable rdata/err until rsp_ready; then go IDLE, rsp_valid drops next cycle.
REQ-029 cmd_ready SHALL be 0 outside IDLE; one outstanding command maximum.
REQ-030 Latency cmd accept -> rsp_valid SHALL be exactly 3 cycles; minimum 4 cycles per command when rsp_ready held high.
REQ-031 reg_sel SHALL be zero in IDLE and RESP; strobes SHALL never be asserted outside ACCESS.
REQ-032 A read immediately following a write to the same word SHALL return the written value.
REQ-033 cmd_* changes while not in IDLE SHALL have no effect.

Reset
REQ-034 On rst: state IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, reg_sel=0, reg_read=0, reg_write=0, reg_sel_ab=0, reg_wdata=0.
REQ-035 Reset asserted mid-ACCESS SHALL drop strobes immediately (asynchronously); pending command discarded, no response issued.

Structure
REQ-036 FSM state encoding and default parameter values SHALL live in shared package reg_bus_pkg.
REQ-037 Address decode (addr -> one-hot plus range error) SHALL be one sub-module, reg_addr_decode; all else in one module.

Verification
REQ-038 Write addr=2 wdata=0xA5 sel_ab=0 -> reg_sel=0x04 SETUP, reg_write=1 one cycle, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-039 Then read addr=2 with reg_ro word2=0xA5 while read -> rsp_rdata=0xA5, rsp_err=0.
REQ-040 Read addr=7 while all other words drive 0xFF on ro -> rsp_rdata equals word7 only.
REQ-041 Command addr=7 with NREGS=6 -> no strobes, reg_sel=0, rsp_err=1, rsp_rdata=0.
REQ-042 rsp_ready held low 5 cycles -> rsp_valid/rdata stable, cmd_ready=0, second cmd_valid ignored until handshake.
REQ-043 rst asserted during ACCESS -> reg_write/reg_read/reg_sel zero before next edge, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus initiator.
// Holds the FSM state encoding and the default parameter values used by
// the initiator, its interface and its address decoder.
package reg_bus_pkg;

   localparam int unsigned NREGS_DEF = 8;
   localparam int unsigned DW_DEF    = 8;
   localparam int unsigned AW_DEF    = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/reg_bus_initiator_if.sv
// Bundle of command, response and register-side signals of the initiator.
//   cmd_*  : command channel (valid/ready), write flag, source select, address, data
//   rsp_*  : response channel (valid/ready), read data, range error
//   reg_*  : register array side: one-hot select, read/write strobes,
//            source select, write data, concatenated ro outputs
// Modport master is the initiator's view; slave is the environment's view.
interface reg_bus_initiator_if
   import reg_bus_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned AW    = AW_DEF
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic                cmd_write;
   logic                cmd_sel_ab;
   logic [AW-1:0]       cmd_addr;
   logic [DW-1:0]       cmd_wdata;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DW-1:0]       rsp_rdata;
   logic                rsp_err;
   logic [NREGS-1:0]    reg_sel;
   logic                reg_read;
   logic                reg_write;
   logic                reg_sel_ab;
   logic [DW-1:0]       reg_wdata;
   logic [NREGS*DW-1:0] reg_ro;

   modport master (
      input  cmd_valid, cmd_write, cmd_sel_ab, cmd_addr, cmd_wdata,
      input  rsp_ready, reg_ro,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output reg_sel, reg_read, reg_write, reg_sel_ab, reg_wdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_sel_ab, cmd_addr, cmd_wdata,
      output rsp_ready, reg_ro,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  reg_sel, reg_read, reg_write, reg_sel_ab, reg_wdata
   );

endinterface

// File: rtl/reg_addr_decode.sv
// Register word address decoder.
//   addr_i : word index
//   sel_o  : one-hot word select, all zero when out of range
//   err_o  : high when addr_i >= NREGS
module reg_addr_decode
   import reg_bus_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic [AW-1:0]    addr_i,
   output logic [NREGS-1:0] sel_o,
   output logic             err_o
);

   always_comb begin
      sel_o = '0;
      err_o = (32'(addr_i) >= NREGS);
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (32'(addr_i) == i) sel_o[i] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: accepts one command at a time and runs it through
// SETUP (select/data driven), ACCESS (one strobe) and RESP (held until
// consumed). Read data is captured at the end of ACCESS.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : command/response/register signals (reg_bus_initiator_if.master)
module reg_bus_initiator
   import reg_bus_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF,
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   reg_bus_initiator_if.master bus
);

   state_e           state_q, state_d;
   logic             write_q, write_d;
   logic             sel_ab_q, sel_ab_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [NREGS-1:0] dec_sel;
   logic             dec_err;
   logic [DW-1:0]    rd_mux;

   // Decode works on the latched address so later cmd_addr changes are ignored.
   reg_addr_decode #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_decode (
      .addr_i (addr_q),
      .sel_o  (dec_sel),
      .err_o  (dec_err)
   );

   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         rd_mux = rd_mux | (bus.reg_ro[i*DW +: DW] & {DW{dec_sel[i]}});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         write_q  <= 1'b0;
         sel_ab_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         sel_ab_q <= sel_ab_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      sel_ab_d      = sel_ab_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.reg_sel   = '0;
      bus.reg_read  = 1'b0;
      bus.reg_write = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               write_d  = bus.cmd_write;
               sel_ab_d = bus.cmd_sel_ab;
               addr_d   = bus.cmd_addr;
               wdata_d  = bus.cmd_wdata;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            bus.reg_sel = dec_sel;
            state_d     = ST_ACCESS;
         end
         ST_ACCESS: begin
            // Out-of-range commands keep reg_sel zero and raise no strobe.
            bus.reg_sel   = dec_sel;
            bus.reg_write = write_q & ~dec_err;
            bus.reg_read  = ~write_q & ~dec_err;
            rdata_d       = (!write_q && !dec_err) ? rd_mux : '0;
            err_d         = dec_err;
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_err    = err_q;
   assign bus.reg_sel_ab = sel_ab_q;
   assign bus.reg_wdata  = wdata_q;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Self-checking bench for reg_bus_initiator: directed commands push expected
// responses into a scoreboard queue; a negedge monitor pops and compares.
module tb_reg_bus_initiator;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_bus_initiator_if #(.NREGS(8), .DW(8), .AW(3)) if8 ();
   reg_bus_initiator_if #(.NREGS(6), .DW(8), .AW(3)) if6 ();

   reg_bus_initiator #(.NREGS(8), .DW(8), .AW(3)) dut8 (.clk(clk), .rst(rst), .bus(if8));
   reg_bus_initiator #(.NREGS(6), .DW(8), .AW(3)) dut6 (.clk(clk), .rst(rst), .bus(if6));

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;

   typedef struct {
      logic [7:0]  rd;
      logic        err;
      int unsigned cyc;
   } exp_t;
   exp_t sbq[$];

   // register array model for the 8-word instance
   logic [7:0]  mem [8];
   logic        model_clr;
   logic        force_en;
   logic [63:0] ro8;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (model_clr) begin
         for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      end else if (if8.reg_write) begin
         for (int i = 0; i < 8; i++) if (if8.reg_sel[i]) mem[i] <= if8.reg_wdata;
      end
   end

   always_comb begin
      ro8 = '0;
      for (int i = 0; i < 8; i++) begin
         if (if8.reg_read) ro8[i*8 +: 8] = force_en ? ((i == 7) ? 8'h3C : 8'hFF) : mem[i];
      end
   end
   assign if8.reg_ro = ro8;
   assign if6.reg_ro = '1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // response monitor and bus protocol monitor
   logic       pv = 1'b0;
   logic [7:0] prd;
   logic       perr;
   always @(negedge clk) begin
      if (rst) begin
         pv <= 1'b0;
      end else begin
         check("bus_protocol",
               32'(!((if8.reg_write || if8.reg_read) &&
                     (if8.cmd_ready || if8.rsp_valid || !$onehot(if8.reg_sel))) &&
                   !((if8.cmd_ready || if8.rsp_valid) && (if8.reg_sel != 8'h00)) &&
                   !(if8.reg_write && if8.reg_read)), 1);
         if (if8.rsp_valid) begin
            check("cmd_ready_in_resp", 32'(if8.cmd_ready), 0);
            if (!pv) begin
               if (sbq.size() == 0) check("rsp_unexpected", sbq.size(), 1);
               else check("rsp_latency", cyc, sbq[0].cyc);
            end else begin
               check("rsp_stable", {if8.rsp_err, if8.rsp_rdata}, {perr, prd});
            end
            if (if8.rsp_ready && sbq.size() > 0) begin
               check("rsp_rdata", 32'(if8.rsp_rdata), 32'(sbq[0].rd));
               check("rsp_err", 32'(if8.rsp_err), 32'(sbq[0].err));
               void'(sbq.pop_front());
            end
         end
         pv   <= if8.rsp_valid && !if8.rsp_ready;
         prd  <= if8.rsp_rdata;
         perr <= if8.rsp_err;
      end
   end

   // Offer one command on the 8-word instance; checks SETUP and ACCESS phases
   // and returns at the start of RESP (posedge + 1).
   task automatic issue(input logic wr, input logic sab, input logic [2:0] a,
                        input logic [7:0] wd, input logic [7:0] esel,
                        input logic [7:0] erd, input logic eerr);
      exp_t e;
      bit   got = 1'b0;
      if8.cmd_write  = wr;
      if8.cmd_sel_ab = sab;
      if8.cmd_addr   = a;
      if8.cmd_wdata  = wd;
      if8.cmd_valid  = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (if8.cmd_ready) begin
            got   = 1'b1;
            e.rd  = erd;
            e.err = eerr;
            e.cyc = cyc + 3;
            sbq.push_back(e);
         end
      end
      if (!got) begin
         check("cmd_accept", 32'(if8.cmd_ready), 1);
         if8.cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      // scramble the command lines; the latched command must be unaffected
      if8.cmd_valid  = 1'b0;
      if8.cmd_write  = ~wr;
      if8.cmd_sel_ab = ~sab;
      if8.cmd_addr   = ~a;
      if8.cmd_wdata  = ~wd;
      @(negedge clk);
      check("setup_sel", 32'(if8.reg_sel), 32'(esel));
      check("setup_strobe", 32'({if8.reg_write, if8.reg_read}), 0);
      check("setup_wdata", 32'(if8.reg_wdata), 32'(wd));
      check("setup_sel_ab", 32'(if8.reg_sel_ab), 32'(sab));
      check("setup_cmd_ready", 32'(if8.cmd_ready), 0);
      @(negedge clk);
      check("access_sel", 32'(if8.reg_sel), 32'(esel));
      check("access_write", 32'(if8.reg_write), 32'(wr && !eerr));
      check("access_read", 32'(if8.reg_read), 32'(!wr && !eerr));
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      model_clr = 1'b1;
      force_en = 1'b0;
      if8.cmd_valid = 1'b0; if8.cmd_write = 1'b0; if8.cmd_sel_ab = 1'b0;
      if8.cmd_addr = '0; if8.cmd_wdata = '0; if8.rsp_ready = 1'b1;
      if6.cmd_valid = 1'b0; if6.cmd_write = 1'b0; if6.cmd_sel_ab = 1'b0;
      if6.cmd_addr = '0; if6.cmd_wdata = '0; if6.rsp_ready = 1'b1;
      repeat (2) @(posedge clk); #1;

      check("rst_cmd_ready", 32'(if8.cmd_ready), 1);
      check("rst_rsp_valid", 32'(if8.rsp_valid), 0);
      check("rst_rsp_rdata", 32'(if8.rsp_rdata), 0);
      check("rst_rsp_err", 32'(if8.rsp_err), 0);
      check("rst_reg_sel", 32'(if8.reg_sel), 0);
      check("rst_strobes", 32'({if8.reg_read, if8.reg_write}), 0);
      check("rst_reg_sel_ab", 32'(if8.reg_sel_ab), 0);
      check("rst_reg_wdata", 32'(if8.reg_wdata), 0);

      model_clr = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      issue(1'b1, 1'b0, 3'd2, 8'hA5, 8'h04, 8'h00, 1'b0);
      issue(1'b0, 1'b0, 3'd2, 8'h00, 8'h04, 8'hA5, 1'b0);
      issue(1'b1, 1'b1, 3'd5, 8'h5A, 8'h20, 8'h00, 1'b0);
      issue(1'b1, 1'b0, 3'd0, 8'hC3, 8'h01, 8'h00, 1'b0);
      issue(1'b0, 1'b1, 3'd5, 8'h00, 8'h20, 8'h5A, 1'b0);
      issue(1'b0, 1'b0, 3'd0, 8'h00, 8'h01, 8'hC3, 1'b0);

      // word 7 drives 0x3C, every other word 0xFF
      force_en = 1'b1;
      issue(1'b0, 1'b0, 3'd7, 8'h00, 8'h80, 8'h3C, 1'b0);
      force_en = 1'b0;

      // response held off for 5 cycles while a second command is offered
      @(posedge clk); #1;
      if8.rsp_ready = 1'b0;
      issue(1'b0, 1'b0, 3'd2, 8'h00, 8'h04, 8'hA5, 1'b0);
      fork
         issue(1'b1, 1'b0, 3'd1, 8'h77, 8'h02, 8'h00, 1'b0);
         begin
            repeat (5) @(posedge clk); #1;
            if8.rsp_ready = 1'b1;
         end
      join
      issue(1'b0, 1'b0, 3'd1, 8'h00, 8'h02, 8'h77, 1'b0);

      // reset in the middle of ACCESS aborts a write to word 3
      issue(1'b1, 1'b0, 3'd3, 8'h11, 8'h08, 8'h00, 1'b0);
      @(posedge clk); #1;
      if8.cmd_write = 1'b1; if8.cmd_addr = 3'd3; if8.cmd_wdata = 8'h99; if8.cmd_valid = 1'b1;
      @(negedge clk);
      check("abort_accept", 32'(if8.cmd_ready), 1);
      @(posedge clk); #1;
      if8.cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_access_write", 32'(if8.reg_write), 1);
      check("abort_access_sel", 32'(if8.reg_sel), 32'h08);
      rst = 1'b1;
      #1;
      check("abort_write_drop", 32'(if8.reg_write), 0);
      check("abort_read_drop", 32'(if8.reg_read), 0);
      check("abort_sel_drop", 32'(if8.reg_sel), 0);
      @(posedge clk); #1;
      check("abort_rsp_valid", 32'(if8.rsp_valid), 0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_cmd_ready", 32'(if8.cmd_ready), 1);
      check("abort_rsp_valid_after", 32'(if8.rsp_valid), 0);
      @(posedge clk); #1;
      issue(1'b0, 1'b0, 3'd3, 8'h00, 8'h08, 8'h11, 1'b0);

      // out-of-range address on the 6-word instance
      if6.cmd_write = 1'b1; if6.cmd_addr = 3'd7; if6.cmd_wdata = 8'h42; if6.cmd_valid = 1'b1;
      @(negedge clk);
      check("n6_accept", 32'(if6.cmd_ready), 1);
      @(posedge clk); #1;
      if6.cmd_valid = 1'b0;
      @(negedge clk);
      check("n6_setup_sel", 32'(if6.reg_sel), 0);
      @(negedge clk);
      check("n6_access_sel", 32'(if6.reg_sel), 0);
      check("n6_access_strobes", 32'({if6.reg_write, if6.reg_read}), 0);
      @(negedge clk);
      check("n6_rsp_valid", 32'(if6.rsp_valid), 1);
      check("n6_rsp_err", 32'(if6.rsp_err), 1);
      check("n6_rsp_rdata", 32'(if6.rsp_rdata), 0);

      for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
      check("sb_drain", sbq.size(), 0);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
